// File: rtl/hilo_div_if.sv
// hilo_div_if: request/result bundle between the EX stage and the HI/LO divider.
//   master : EX side; drives start/signed/cancel and both operands, receives
//            the stall request and the HI/LO write (ready, we, hi, lo).
//   slave  : divider side; the reverse directions.
interface hilo_div_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             signed_i;
  logic             cancel_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             stall_o;
  logic             ready_o;
  logic             hilo_we_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, signed_i, cancel_i, dividend_i, divisor_i,
    input  stall_o, ready_o, hilo_we_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, signed_i, cancel_i, dividend_i, divisor_i,
    output stall_o, ready_o, hilo_we_o, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_div_unit.sv
// hilo_div_unit: iterative radix-2 restoring divider (DIV/DIVU) feeding HI/LO.
//   clk, rst : clock and synchronous active-high reset
//   bus      : hilo_div_if.slave
//     start_i/signed_i/dividend_i/divisor_i : request, sampled in IDLE
//     cancel_i  : pipeline flush, aborts the op and suppresses the write
//     stall_o   : stall request while the op is being accepted or computed
//     ready_o   : result valid (END state)
//     hilo_we_o : one-cycle write pulse on the first END cycle
//     hi_o/lo_o : remainder / quotient, held until the next result
// Divide by zero yields hi=dividend, lo=all ones; -2^(W-1)/-1 wraps.
module hilo_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  hilo_div_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] rem_reg;       // partial remainder (always < divisor)
  logic [WIDTH-1:0] quo_reg;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_reg;       // divisor magnitude
  logic [WIDTH-1:0] dividend_reg;  // raw dividend, needed for the divide-by-zero result
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             ready_reg;
  logic             we_reg;

  // Operand magnitudes at acceptance time
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_neg = bus.signed_i & bus.dividend_i[WIDTH-1];
  assign b_neg = bus.signed_i & bus.divisor_i[WIDTH-1];
  assign a_mag = a_neg ? (~bus.dividend_i + 1'b1) : bus.dividend_i;
  assign b_mag = b_neg ? (~bus.divisor_i + 1'b1) : bus.divisor_i;

  // One restoring step: the shifted partial remainder is WIDTH+1 bits wide, so
  // the trial subtraction's top bit is a reliable sign.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign shifted = {rem_reg, quo_reg[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_reg};

  always_comb begin
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo_reg[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo_reg[WIDTH-2:0], 1'b1};
    end
  end

  // Sign fixup applied to the final step's result on the way into END
  assign q_fix = neg_q_reg ? (~quo_next + 1'b1) : quo_next;
  assign r_fix = neg_r_reg ? (~rem_next + 1'b1) : rem_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      dvs_reg      <= '0;
      dividend_reg <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      ready_reg    <= 1'b0;
      we_reg       <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          ready_reg <= 1'b0;
          we_reg    <= 1'b0;
          if (bus.start_i && !bus.cancel_i) begin
            dividend_reg <= bus.dividend_i;
            dvs_reg      <= b_mag;
            quo_reg      <= a_mag;
            rem_reg      <= '0;
            cnt_reg      <= '0;
            neg_q_reg    <= a_neg ^ b_neg;
            neg_r_reg    <= a_neg;
            state_reg    <= (bus.divisor_i == '0) ? S_BYZERO : S_ON;
          end
        end
        S_BYZERO: begin
          if (bus.cancel_i) begin
            state_reg <= S_IDLE;
          end else begin
            hi_reg    <= dividend_reg;
            lo_reg    <= '1;
            ready_reg <= 1'b1;
            we_reg    <= 1'b1;
            state_reg <= S_END;
          end
        end
        S_ON: begin
          if (bus.cancel_i) begin
            state_reg <= S_IDLE;
          end else begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CW'(WIDTH - 1)) begin
              hi_reg    <= r_fix;
              lo_reg    <= q_fix;
              ready_reg <= 1'b1;
              we_reg    <= 1'b1;
              state_reg <= S_END;
            end
          end
        end
        S_END: begin
          we_reg <= 1'b0;
          // EX keeps start_i high until it sees the result; wait for it to drop
          if (bus.cancel_i || !bus.start_i) begin
            ready_reg <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.stall_o   = ((state_reg == S_IDLE) && bus.start_i && !bus.cancel_i) ||
                         (state_reg == S_BYZERO) || (state_reg == S_ON);
  assign bus.ready_o   = ready_reg;
  // A flush arriving on the first END cycle must still kill the write
  assign bus.hilo_we_o = we_reg & ~bus.cancel_i;
  assign bus.hi_o      = hi_reg;
  assign bus.lo_o      = lo_reg;
endmodule

// File: tb/tb_hilo_div_unit.sv
module tb_hilo_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hilo_div_if #(.WIDTH(W)) bus ();

  hilo_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every write pulse must match the oldest pending expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && bus.hilo_we_o) begin
      if (sb_q.size() == 0) begin
        $display("txn unexpected we hi=%h lo=%h cyc=%0d", bus.hi_o, bus.lo_o, cyc);
        check("unexpected_we", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        $display("txn %s hi=%h lo=%h cyc=%0d", e.name, bus.hi_o, bus.lo_o, cyc);
        check({e.name, "_hi"}, 64'(bus.hi_o), 64'(e.hi));
        check({e.name, "_lo"}, 64'(bus.lo_o), 64'(e.lo));
        check({e.name, "_cyc"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Issue one op, scramble the operands after acceptance, hold start through END
  task automatic run_op(input string name, input bit sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input int hold_extra);
    exp_t e;
    int   n;
    int   exp_stall;
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.signed_i   = sgn;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    exp_stall = (b == '0) ? 2 : W + 1;
    e.name = name;
    e.hi   = ehi;
    e.lo   = elo;
    e.cyc  = cyc + exp_stall;
    sb_q.push_back(e);
    #1;
    n = 0;
    while (bus.stall_o && n < 4 * W) begin
      n++;
      @(negedge clk);
      bus.dividend_i = ~bus.dividend_i;
      bus.divisor_i  = bus.divisor_i + 1'b1;
      bus.signed_i   = ~sgn;
      #1;
    end
    check({name, "_stall"}, 64'(n), 64'(exp_stall));
    check({name, "_ready"}, 64'(bus.ready_o), 64'd1);
    repeat (hold_extra) @(negedge clk);
    if (hold_extra > 0) check({name, "_ready_hold"}, 64'(bus.ready_o), 64'd1);
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] hi0;
    logic [W-1:0] lo0;
    bus.start_i    = 1'b0;
    bus.signed_i   = 1'b0;
    bus.cancel_i   = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_hi",    64'(bus.hi_o), 64'd0);
    check("rst_lo",    64'(bus.lo_o), 64'd0);
    check("rst_ready", 64'(bus.ready_o), 64'd0);
    check("rst_we",    64'(bus.hilo_we_o), 64'd0);
    check("rst_stall", 64'(bus.stall_o), 64'd0);

    run_op("divu_100_7",  1'b0, 32'd100,        32'd7,          32'd2,          32'd14,         3);
    run_op("div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  0);
    run_op("div_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  0);
    run_op("div_m100_m7", 1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd14,         0);
    run_op("divu_by0",    1'b0, 32'h0000_1234,  32'd0,          32'h0000_1234,  32'hFFFF_FFFF,  2);
    run_op("div_by0",     1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  32'hFFFF_FFFF,  0);
    run_op("div_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  0);
    run_op("divu_ovf",    1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          0);
    run_op("divu_big",    1'b0, 32'hFFFF_FFFF,  32'h0000_0010,  32'h0000_000F,  32'h0FFF_FFFF,  0);
    run_op("divu_small",  1'b0, 32'd5,          32'd9,          32'd5,          32'd0,          0);

    // Flush at ON cycle 10: no write, result registers untouched
    hi0 = bus.hi_o;
    lo0 = bus.lo_o;
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.signed_i   = 1'b0;
    bus.dividend_i = 32'd1000;
    bus.divisor_i  = 32'd3;
    repeat (10) @(negedge clk);
    bus.cancel_i = 1'b1;
    bus.start_i  = 1'b0;
    @(negedge clk);
    bus.cancel_i = 1'b0;
    #1;
    $display("txn cancel_on stall=%b ready=%b hi=%h lo=%h", bus.stall_o, bus.ready_o, bus.hi_o, bus.lo_o);
    check("cancel_stall", 64'(bus.stall_o), 64'd0);
    check("cancel_ready", 64'(bus.ready_o), 64'd0);
    check("cancel_hi",    64'(bus.hi_o), 64'(hi0));
    check("cancel_lo",    64'(bus.lo_o), 64'(lo0));
    repeat (W + 5) @(negedge clk);

    // Cancel together with start in IDLE: must not begin an op
    bus.start_i    = 1'b1;
    bus.cancel_i   = 1'b1;
    bus.dividend_i = 32'd5;
    bus.divisor_i  = 32'd1;
    #1;
    check("cancel_start_stall", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    bus.start_i  = 1'b0;
    bus.cancel_i = 1'b0;
    #1;
    $display("txn cancel_start stall=%b ready=%b", bus.stall_o, bus.ready_o);
    check("cancel_start_idle", 64'(bus.stall_o), 64'd0);
    repeat (W + 5) @(negedge clk);

    // Reset during ON cycle 5 clears every output
    bus.start_i    = 1'b1;
    bus.dividend_i = 32'd77;
    bus.divisor_i  = 32'd5;
    repeat (5) @(negedge clk);
    rst         = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    #1;
    $display("txn reset_mid hi=%h lo=%h ready=%b we=%b stall=%b",
             bus.hi_o, bus.lo_o, bus.ready_o, bus.hilo_we_o, bus.stall_o);
    check("midrst_hi",    64'(bus.hi_o), 64'd0);
    check("midrst_lo",    64'(bus.lo_o), 64'd0);
    check("midrst_ready", 64'(bus.ready_o), 64'd0);
    check("midrst_stall", 64'(bus.stall_o), 64'd0);
    rst = 1'b0;

    run_op("divu_1000_3", 1'b0, 32'd1000, 32'd3, 32'd1, 32'd333, 1);
    repeat (4) @(negedge clk);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
